// File: rtl/disp_digit_wr_sched.sv
// Round-robin scheduler for the digit display buffer write port: converts the
// granted requester's binary value to BCD (serial double-dabble) and writes its digits.
module disp_digit_wr_sched #(
    parameter int         NUM_REQ    = 3,
    parameter int         VAL_W      = 16,
    parameter int         NUM_DIG    = 5,
    parameter int         MAX_DISP   = 128,
    parameter int         LZ_BLANK   = 1,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic                     disp_clk,
    input  logic                     rst_disp,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*VAL_W-1:0] i_val,
    input  logic [NUM_REQ*7-1:0]     i_base_adr,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic                     o_busy,
    output logic                     o_disp_wen,
    output logic                     o_disp_men,
    output logic [6:0]               o_disp_adr,
    output logic [3:0]               o_disp_d
);
    localparam int BCD_W = NUM_DIG * 4;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(VAL_W + NUM_DIG + 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(VAL_W - 1);
    localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(NUM_DIG - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_WRITE} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [VAL_W-1:0] bin_q,   bin_d;
    logic [6:0]       base_q,  base_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             seen_q,  seen_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic             busy_q,  busy_d;
    logic             stb_n_q, stb_n_d;
    logic [6:0]       adr_q,   adr_d;
    logic [3:0]       dig_q,   dig_d;

    logic             found;
    logic [PTR_W-1:0] gnt;
    logic [PTR_W-1:0] idx;
    logic [BCD_W-1:0] bcd_nx;

    // First requester above the pointer wins, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        idx   = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // One double-dabble step; the carry out of the top digit is dropped (mod 10^NUM_DIG).
    always_comb begin
        logic [3:0] nib;
        logic       cin;
        bcd_nx = '0;
        cin    = bin_q[VAL_W-1];
        for (int n = 0; n < NUM_DIG; n++) begin
            nib = bcd_q[n*4 +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_nx[n*4 +: 4] = {nib[2:0], cin};
            cin = nib[3];
        end
    end

    logic             emit;
    logic             emit_seen;
    logic [CNT_W-1:0] emit_idx;
    logic [BCD_W-1:0] emit_src;
    logic [3:0]       emit_dig;
    logic [7:0]       emit_adr;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        bin_d     = bin_q;
        base_d    = base_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        ack_d     = '0;
        stb_n_d   = 1'b1;
        adr_d     = adr_q;
        dig_d     = dig_q;
        emit      = 1'b0;
        emit_seen = 1'b0;
        emit_idx  = '0;
        emit_src  = '0;
        emit_dig  = '0;
        emit_adr  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d      = gnt;
                    bin_d      = i_val[int'(gnt)*VAL_W +: VAL_W];
                    base_d     = i_base_adr[int'(gnt)*7 +: 7];
                    ack_d[gnt] = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_nx;
                if (cnt_q == CONV_LAST) begin
                    emit     = 1'b1;
                    emit_src = bcd_nx;
                    cnt_d    = '0;
                    state_d  = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WRITE: begin
                if (cnt_q == DIG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    emit      = 1'b1;
                    emit_idx  = cnt_q + CNT_ONE;
                    emit_src  = bcd_q;
                    emit_seen = seen_q;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded one cycle ahead with the digit to show next.
        if (emit) begin
            emit_dig = emit_src[BCD_W-1 -: 4];
            emit_adr = {1'b0, base_q} + 8'(emit_idx);
            bcd_d    = emit_src << 4;
            seen_d   = emit_seen || (emit_dig != 4'd0);
            adr_d    = emit_adr[6:0];
            dig_d    = (LZ_BLANK != 0 && !seen_d && emit_idx != DIG_LAST) ? BLANK_CODE : emit_dig;
            stb_n_d  = (int'(emit_adr) >= MAX_DISP);
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge disp_clk) begin
        if (rst_disp) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            bin_q   <= '0;
            base_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            stb_n_q <= 1'b1;
            adr_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bin_q   <= bin_d;
            base_q  <= base_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            stb_n_q <= stb_n_d;
            adr_q   <= adr_d;
            dig_q   <= dig_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_disp_wen = stb_n_q;
    assign o_disp_men = stb_n_q;
    assign o_disp_adr = adr_q;
    assign o_disp_d   = dig_q;
endmodule
